// File: rtl/ycr_cclk_pkg.sv
// Shared state encoding, mode constants and wake-settle length for the
// ycr_cclk clock-gate controller.
package ycr_cclk_pkg;

    typedef enum logic [1:0] {
        RUN       = 2'b00,
        IDLE_WAIT = 2'b01,
        GATED     = 2'b10,
        WAKE      = 2'b11
    } cclk_st_e;

    localparam logic [1:0] CCLK_ON       = 2'b00;
    localparam logic [1:0] CCLK_OFF      = 2'b01;
    localparam logic [1:0] CCLK_AUTO_REQ = 2'b10;
    localparam logic [1:0] CCLK_AUTO_IRQ = 2'b11;

    localparam int unsigned WAKE_CYC = 2;

endpackage

// File: rtl/ctech_clk_gate.sv
// Behavioural latch-based clock gate: enable is captured while CLK is low,
// so GCLK never glitches when GATE changes.
module ctech_clk_gate (
    input  logic GATE,
    input  logic CLK,
    output logic GCLK
);

    logic en_lat;

    always_latch begin
        if (!CLK) en_lat <= GATE;
    end

    assign GCLK = CLK & en_lat;

endmodule

// File: rtl/ycr_cclk_gate_ch.sv
// One gated-clock channel: mode/idle FSM, idle-delay counter, wake settle,
// gate cell and (with YCR_CCLK_GATE_STATS_EN) a gated-cycle counter.
module ycr_cclk_gate_ch
    import ycr_cclk_pkg::*;
#(
    parameter int unsigned IDLE_CNT_W = 8
) (
    input  logic                  core_clk_int,
    input  logic                  rst_n,
    input  logic [1:0]            cfg_mode,
    input  logic [IDLE_CNT_W-1:0] cfg_idle_dly,
    input  logic                  ch_idle,
    input  logic                  ch_req,
    input  logic                  wake_any,
`ifdef YCR_CCLK_GATE_STATS_EN
    input  logic                  stats_clr,
    output logic [15:0]           gate_cnt,
`endif
    output logic                  clk_enb,
    output logic                  ch_clk,
    output logic                  ch_awake
);

    localparam int unsigned WK_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC) : 1;

    cclk_st_e              st, st_nxt;
    logic [IDLE_CNT_W-1:0] cnt, cnt_nxt;
    logic [WK_W-1:0]       wk, wk_nxt;
    logic                  wake_ev;

    assign wake_ev = ch_req | ((cfg_mode == CCLK_AUTO_IRQ) & wake_any);

    // Mode decode sits outside the state case so a mode change beats every transition.
    always_comb begin
        st_nxt  = st;
        cnt_nxt = cnt;
        wk_nxt  = wk;
        case (cfg_mode)
            CCLK_ON: begin
                st_nxt  = RUN;
                cnt_nxt = '0;
                wk_nxt  = '0;
            end
            CCLK_OFF: begin
                st_nxt  = GATED;
                cnt_nxt = '0;
                wk_nxt  = '0;
            end
            default: begin
                case (st)
                    RUN: begin
                        if (ch_idle && !wake_ev) begin
                            if (cfg_idle_dly == '0) begin
                                st_nxt = GATED;
                            end else begin
                                st_nxt  = IDLE_WAIT;
                                cnt_nxt = cfg_idle_dly;
                            end
                        end
                    end
                    IDLE_WAIT: begin
                        if (!ch_idle || wake_ev) begin
                            st_nxt  = RUN;
                            cnt_nxt = '0;
                        end else if (cnt == IDLE_CNT_W'(1)) begin
                            st_nxt  = GATED;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt - IDLE_CNT_W'(1);
                        end
                    end
                    GATED: begin
                        if (wake_ev) begin
                            st_nxt = WAKE;
                            wk_nxt = WK_W'(WAKE_CYC - 1);
                        end
                    end
                    WAKE: begin
                        if (wk == '0) st_nxt = RUN;
                        else          wk_nxt = wk - WK_W'(1);
                    end
                    default: st_nxt = RUN;
                endcase
            end
        endcase
    end

    always_ff @(posedge core_clk_int or negedge rst_n) begin
        if (!rst_n) begin
            st       <= RUN;
            cnt      <= '0;
            wk       <= '0;
            clk_enb  <= 1'b1;
            ch_awake <= 1'b1;
        end else begin
            st       <= st_nxt;
            cnt      <= cnt_nxt;
            wk       <= wk_nxt;
            clk_enb  <= (st != GATED);
            ch_awake <= (st == RUN);
        end
    end

`ifdef YCR_CCLK_GATE_STATS_EN
    always_ff @(posedge core_clk_int or negedge rst_n) begin
        if (!rst_n)                              gate_cnt <= '0;
        else if (stats_clr)                      gate_cnt <= '0;
        else if (st == GATED && gate_cnt != '1)  gate_cnt <= gate_cnt + 16'd1;
    end
`endif

    ctech_clk_gate u_cg (
        .GATE (clk_enb),
        .CLK  (core_clk_int),
        .GCLK (ch_clk)
    );

endmodule

// File: rtl/ycr_cclk_gate_ctrl_n.sv
// N-channel clock-gate controller: wake-source synchronisers plus one
// ycr_cclk_gate_ch per channel. Optional stats via YCR_CCLK_GATE_STATS_EN.
module ycr_cclk_gate_ctrl_n
    import ycr_cclk_pkg::*;
#(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned IDLE_CNT_W = 8,
    parameter int unsigned NUM_WAKE   = 3
) (
    input  logic                         core_clk_int,
    input  logic                         rst_n,
    input  logic [2*NUM_CH-1:0]          cfg_mode,
    input  logic [IDLE_CNT_W*NUM_CH-1:0] cfg_idle_dly,
    input  logic [NUM_CH-1:0]            ch_idle,
    input  logic [NUM_CH-1:0]            ch_req,
    input  logic [NUM_WAKE-1:0]          wake_irq,
`ifdef YCR_CCLK_GATE_STATS_EN
    input  logic                         stats_clr,
    output logic [16*NUM_CH-1:0]         gate_cnt,
`endif
    output logic [NUM_CH-1:0]            clk_enb,
    output logic [NUM_CH-1:0]            ch_clk,
    output logic [NUM_CH-1:0]            ch_awake
);

    logic [NUM_WAKE-1:0] wk_s1, wk_s2;
    logic                wake_any;

    always_ff @(posedge core_clk_int or negedge rst_n) begin
        if (!rst_n) begin
            wk_s1 <= '0;
            wk_s2 <= '0;
        end else begin
            wk_s1 <= wake_irq;
            wk_s2 <= wk_s1;
        end
    end

    assign wake_any = |wk_s2;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ycr_cclk_gate_ch #(
            .IDLE_CNT_W (IDLE_CNT_W)
        ) u_ch (
            .core_clk_int (core_clk_int),
            .rst_n        (rst_n),
            .cfg_mode     (cfg_mode[2*i +: 2]),
            .cfg_idle_dly (cfg_idle_dly[IDLE_CNT_W*i +: IDLE_CNT_W]),
            .ch_idle      (ch_idle[i]),
            .ch_req       (ch_req[i]),
            .wake_any     (wake_any),
`ifdef YCR_CCLK_GATE_STATS_EN
            .stats_clr    (stats_clr),
            .gate_cnt     (gate_cnt[16*i +: 16]),
`endif
            .clk_enb      (clk_enb[i]),
            .ch_clk       (ch_clk[i]),
            .ch_awake     (ch_awake[i])
        );
    end

endmodule

// File: doc/ycr_cclk_gate_ctrl_n.md
Name: ycr_cclk_gate_ctrl_n

Overview:
- Parametrised N-channel clock-gate controller; successor to the fixed AES/FPU/core gating top.
- Each channel has its own mode, idle-hysteresis delay, wake handshake and gated clock output.
- Sits between the core clock root and the RISC-V sub-blocks: cores, FPU, AES and future accelerators.
- Adds per-channel programmable idle delay and a wake-acknowledge status.

Parameters:
NUM_CH, 4, number of gated clock channels
IDLE_CNT_W, 8, width of per-channel idle-delay counter
NUM_WAKE, 3, number of asynchronous wake/irq sources (synchronised internally)

Ports:
core_clk_int  input  1  ungated core clock; all logic on this clock
rst_n  input  1  reset; asynchronous assert, active low
cfg_mode  input  2*NUM_CH  per-channel mode, 00 always-on, 01 forced-off, 10 auto (req wake), 11 auto (req or irq wake)
cfg_idle_dly  input  IDLE_CNT_W*NUM_CH  idle cycles required before gating
ch_idle  input  NUM_CH  1 = destination idle (core_clk_int domain)
ch_req  input  NUM_CH  1 = source request to channel
wake_irq  input  NUM_WAKE  async wake sources, OR-reduced after sync
clk_enb  output  NUM_CH  registered gate enable
ch_clk  output  NUM_CH  gated clocks
ch_awake  output  NUM_CH  1 = channel in RUN (clock stable, may accept work)

Behaviour:
- wake_irq: each bit 2-flop synchronised, reset 0; wake_any = OR of synchronised bits, 2-cycle latency.
- Per-channel FSM: RUN, IDLE_WAIT, GATED, WAKE. Reset: state RUN, clk_enb=1, ch_awake=1, counter 0.
- Mode 00: state forced to RUN next cycle; clk_enb=1.
- Mode 01: state forced to GATED next cycle; clk_enb=0; wake events ignored.
- Auto modes (1x), wake_ev = ch_req, OR (mode==11 AND wake_any).
- RUN -> IDLE_WAIT when ch_idle=1 and wake_ev=0; counter loads cfg_idle_dly.
- RUN -> GATED directly if cfg_idle_dly==0.
- IDLE_WAIT:
  - if ch_idle=0 or wake_ev=1 -> RUN, and the counter clears.
  - else counter decrements; -> GATED on the cycle the counter reads 1.
  - Gate occurs exactly cfg_idle_dly cycles after entry.
- GATED -> WAKE when wake_ev=1.
- WAKE: clk_enb=1, ch_awake=0, held exactly 2 cycles for clock settle, then -> RUN. Idle is not sampled in WAKE.
- clk_enb = (state != GATED), registered. ch_clk produced by ctech_clk_gate with GATE=clk_enb, so first gated-off edge is the cycle after clk_enb falls.
- ch_awake = (state == RUN), registered.
- Simultaneous events: wake_ev beats ch_idle in every state. A mode change beats all FSM transitions.
- cfg_idle_dly change during IDLE_WAIT has no effect until the next entry.
- Async reset mid-operation: all channels return to RUN/enabled immediately, with no glitch on ch_clk because of the latch-based gate cell.

Optional Feature:
- Macro: YCR_CCLK_GATE_STATS_EN.
- Defined:
  - Adds output gate_cnt, 16*NUM_CH wide.
  - Per-channel saturating counter of core_clk_int cycles spent in GATED; reset 0, saturates at 16'hFFFF.
  - Adds input stats_clr, 1 bit: synchronous clear of all counters, taking priority over increment.
- Undefined: ports absent, no counters.

Decomposition:
- Package ycr_cclk_pkg:
  - state enum cclk_st_e {RUN, IDLE_WAIT, GATED, WAKE}.
  - Mode constants CCLK_ON=2'b00, CCLK_OFF=2'b01, CCLK_AUTO_REQ=2'b10, CCLK_AUTO_IRQ=2'b11.
  - WAKE_CYC=2.
- Sub-module ycr_cclk_gate_ch: one channel FSM, counter, optional stats and ctech_clk_gate instance.
- Top holds the wake synchronisers and a generate loop over NUM_CH.

Test Plan:
- Reset release with all modes 00 -> clk_enb=4'hF, ch_awake=4'hF, ch_clk toggles on all channels.
- ch0 mode 10, dly=5, ch_idle[0] rises at cycle T -> clk_enb[0] falls at T+5 (registered, visible T+6); ch_clk[0] stops the following edge.
- ch1 gated, ch_req[1] pulse 1 cycle -> clk_enb[1]=1 next cycle; ch_awake[1]=1 exactly 3 cycles after req.
- ch2 mode 11 gated, wake_irq[1] async pulse 3 cycles -> wake within 3 cycles; repeat with mode 10 -> stays gated.
- ch3 in IDLE_WAIT, dly=10, ch_idle drops at count 4 -> back to RUN with no gating; simultaneous ch_idle=1 and ch_req=1 -> stays RUN.
- Mode 01 while in WAKE -> GATED next cycle. With STATS_EN: 20 gated cycles -> gate_cnt=20; stats_clr -> 0.
